// File: rtl/fpcvt_pkg.sv
// Shared definitions for the FPCVT scheduler.
// Contents: operand/result field widths, scheduler FSM state type and the
// wrapped round-robin pointer increment.
package fpcvt_pkg;
    localparam int D_W = 13;  // two's-complement sample width
    localparam int E_W = 3;   // exponent width
    localparam int F_W = 5;   // significand width

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    // Next round-robin start position: one past the winner, wrapping to 0.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction
endpackage

// File: rtl/fpcvt_sched_if.sv
// Request/result bus of the FPCVT scheduler.
// slave : scheduler side (takes requests, produces results)
// master: requester/sink side
//   req_valid/req_data/req_ready : per-requester operand handshake
//   res_valid/res_ready          : result handshake
//   res_id/res_s/res_e/res_f     : result payload
interface fpcvt_sched_if
    import fpcvt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]     req_valid;
    logic [D_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic                   res_s;
    logic [E_W-1:0]         res_e;
    logic [F_W-1:0]         res_f;

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_s, res_e, res_f
    );
    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_s, res_e, res_f
    );
endinterface

// File: rtl/fpcvt.sv
// FPCVT: 13-bit two's-complement to sign/exponent/significand conversion.
// Value is approximately (-1)^s * f * 2^e; low-order bits are truncated and
// the one magnitude that does not fit (-4096) saturates to e=7, f=31.
//   d : operand in
//   s : sign out, e : exponent out, f : significand out
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic [D_W-1:0] d,
    output logic           s,
    output logic [E_W-1:0] e,
    output logic [F_W-1:0] f
);
    logic [D_W-1:0] mag;

    assign s   = d[D_W-1];
    assign mag = s ? (~d + 1'b1) : d;

    always_comb begin
        e = '0;
        f = mag[F_W-1:0];
        if (mag[D_W-1]) begin
            // only reachable for the most negative operand
            e = '1;
            f = '1;
        end else begin
            // ascending scan so the highest set bit wins
            for (int i = F_W; i < D_W - 1; i++) begin
                if (mag[i]) begin
                    e = E_W'(i - F_W + 1);
                    f = mag[i -: F_W];
                end
            end
        end
    end
endmodule

// File: rtl/fpcvt_rr_arb.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   rr_ptr  : index the search starts from (owned by the caller)
//   en      : grant enable; gnt is all-zero when low
//   gnt     : one-hot grant
//   gnt_idx : binary index of the winner (valid when any_req)
//   any_req : at least one request present
module fpcvt_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_req
);
    logic found;
    int   j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'((32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ));
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(j);
                gnt[j]  = en;
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one FPCVT among NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result interface (slave side)
// A grant is offered in IDLE, or in HOLD in the same cycle the result is
// taken, so back-to-back traffic yields one result every two cycles.
module fpcvt_sched
    import fpcvt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    fpcvt_sched_if.slave  bus
);
    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_reg;
    logic [D_W-1:0]     op_reg;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_req;
    logic               arb_en;
    logic               accept;
    logic               cv_s;
    logic [E_W-1:0]     cv_e;
    logic [F_W-1:0]     cv_f;

    // rst_n in the enable keeps req_ready low while reset is held
    assign arb_en = rst_n && ((state == IDLE) || (state == HOLD && bus.res_ready));
    assign accept = arb_en && any_req;

    fpcvt_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign bus.req_ready = gnt;

    fpcvt u_cvt (
        .d (op_reg),
        .s (cv_s),
        .e (cv_e),
        .f (cv_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_reg        <= '0;
            op_reg        <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_s     <= 1'b0;
            bus.res_e     <= '0;
            bus.res_f     <= '0;
        end else begin
            // accept is only possible from IDLE or a draining HOLD
            if (accept) begin
                op_reg <= bus.req_data[32'(gnt_idx) * D_W +: D_W];
                id_reg <= gnt_idx;
                rr_ptr <= ID_W'(rr_next(32'(gnt_idx), NUM_REQ));
            end
            case (state)
                IDLE: if (accept) state <= CONV;
                CONV: begin
                    bus.res_s     <= cv_s;
                    bus.res_e     <= cv_e;
                    bus.res_f     <= cv_f;
                    bus.res_id    <= id_reg;
                    bus.res_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: if (bus.res_ready) begin
                    bus.res_valid <= 1'b0;
                    state         <= accept ? CONV : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpcvt_sched.sv
module tb_fpcvt_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpcvt_sched_if #(.NUM_REQ(N)) bus ();

    fpcvt_sched #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int s;
        int e;
        int f;
        int due;
    } item_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    mptr  = 0;
    item_t exp_q[$];
    item_t log_q[$];
    int    src_q[N][$];

    // conversion reference: halve until the magnitude fits in 5 bits
    function automatic logic [8:0] fmodel(input int d);
        int m;
        int e;
        m = (d < 0) ? -d : d;
        e = 0;
        if (m >= 4096) return {(d < 0), 3'd7, 5'd31};
        while (m > 31) begin
            m = m / 2;
            e++;
        end
        return {(d < 0), 3'(e), 5'(m)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // requester sources: each presents the head of its queue until accepted
    initial begin
        logic [N-1:0] hs;
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[13*i +: 13] = 13'(src_q[i][0]);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // reference model + per-cycle compare
    initial begin
        bit          free;
        bit          ev;
        int          w;
        int          j;
        logic [N-1:0] er;
        logic [8:0]  r;
        item_t       it;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_res_valid", int'(bus.res_valid), 0);
                chk("rst_req_ready", int'(bus.req_ready), 0);
                exp_q.delete();
                mptr = 0;
            end else begin
                free = (exp_q.size() == 0) || (exp_q[0].due <= cyc && bus.res_ready);
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (w < 0 && bus.req_valid[j]) w = j;
                end
                er = (free && w >= 0) ? N'(1 << w) : '0;
                chk("req_ready", int'(bus.req_ready), int'(er));
                ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
                chk("res_valid", int'(bus.res_valid), int'(ev));
                if (ev) begin
                    chk("res_id", int'(bus.res_id), exp_q[0].id);
                    chk("res_s",  int'(bus.res_s),  exp_q[0].s);
                    chk("res_e",  int'(bus.res_e),  exp_q[0].e);
                    chk("res_f",  int'(bus.res_f),  exp_q[0].f);
                    if (bus.res_ready) begin
                        it = exp_q.pop_front();
                        it.due = cyc;
                        log_q.push_back(it);
                    end
                end
                if (free && w >= 0) begin
                    r = fmodel(int'($signed(bus.req_data[13*w +: 13])));
                    it.id = w; it.s = int'(r[8]); it.e = int'(r[7:5]); it.f = int'(r[4:0]);
                    it.due = cyc + 2;
                    exp_q.push_back(it);
                    mptr = (w + 1) % N;
                end
            end
        end
    end

    task automatic wait_done(input int budget, input string nm);
        int  n;
        bit  busy;
        n = 0;
        forever begin
            busy = (exp_q.size() != 0) || bus.res_valid;
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) busy = 1'b1;
            if (!busy) break;
            if (n >= budget) begin
                tests++;
                fails++;
                $display("FAIL %s: timeout after %0d cycles, expected drain", nm, n);
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rdy(input int idx, input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready[idx]) break;
            if (++n >= 30) begin
                tests++;
                fails++;
                $display("FAIL %s: req_ready[%0d] never rose, expected grant", nm, idx);
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    int vals[7]  = '{-5, 0, -4096, 4095, 32, 100, -1};
    int xs[7]    = '{1, 0, 1, 0, 0, 0, 1};
    int xe[7]    = '{0, 0, 7, 7, 1, 2, 0};
    int xf[7]    = '{5, 0, 31, 31, 16, 25, 1};

    initial begin
        int sid, ss, se, sf;
        int n;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;

        // reset state, request held during reset must not be granted
        src_q[2].push_back(5);
        repeat (3) tick();
        chk("reset_res_valid", int'(bus.res_valid), 0);
        chk("reset_res_id", int'(bus.res_id), 0);
        chk("reset_res_sef", int'({bus.res_s, bus.res_e, bus.res_f}), 0);
        chk("reset_req_ready", int'(bus.req_ready), 0);
        rst_n = 1'b1;
        wait_done(50, "single");
        chk("single_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("single_id", log_q[0].id, 2);
            chk("single_s", log_q[0].s, 0);
            chk("single_e", log_q[0].e, 0);
            chk("single_f", log_q[0].f, 5);
        end

        // reset while converting drops the operand
        log_q.delete();
        src_q[0].push_back(100);
        wait_rdy(0, "midconv_grant");
        tick();
        rst_n = 1'b0;
        #1;
        chk("midconv_res_valid", int'(bus.res_valid), 0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("midconv_no_result", log_q.size(), 0);

        // sign and edge values from one requester
        log_q.delete();
        for (int i = 0; i < 7; i++) src_q[1].push_back(vals[i]);
        wait_done(200, "edges");
        chk("edges_count", log_q.size(), 7);
        if (log_q.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                chk("edges_id", log_q[i].id, 1);
                chk("edges_s", log_q[i].s, xs[i]);
                chk("edges_e", log_q[i].e, xe[i]);
                chk("edges_f", log_q[i].f, xf[i]);
            end
        end

        // all requesters saturated: grants 0,1,2,3,... every 2 cycles
        do_reset();
        log_q.delete();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                src_q[i].push_back((i + 1) * (k + 1) * 97 * ((k == 1) ? -1 : 1));
        wait_done(300, "rr_all");
        chk("rr_all_count", log_q.size(), 12);
        if (log_q.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                chk("rr_all_order", log_q[k].id, k % N);
                if (k > 0) chk("rr_all_spacing", log_q[k].due - log_q[k-1].due, 2);
            end
        end

        // backpressure: result held, no grants, then same-cycle accept
        log_q.delete();
        bus.res_ready = 1'b0;
        src_q[0].push_back(77);
        n = 0;
        while (!bus.res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid", int'(bus.res_valid), 1);
        src_q[3].push_back(-300);
        sid = int'(bus.res_id); ss = int'(bus.res_s); se = int'(bus.res_e); sf = int'(bus.res_f);
        chk("bp_first_e", se, 2);
        chk("bp_first_f", sf, 19);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(bus.res_valid), 1);
            chk("bp_hold_payload", int'({bus.res_id, bus.res_s, bus.res_e, bus.res_f}),
                (sid << 9) | (ss << 8) | (se << 5) | sf);
            chk("bp_hold_ready", int'(bus.req_ready), 0);
        end
        tick();
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_grant", int'(bus.req_ready), 8);
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_gap", int'(bus.res_valid), 0);
        @(negedge clk);
        chk("bp_next_valid", int'(bus.res_valid), 1);
        chk("bp_next_id", int'(bus.res_id), 3);
        chk("bp_next_sef", int'({bus.res_s, bus.res_e, bus.res_f}), (1 << 8) | (4 << 5) | 18);
        wait_done(50, "bp");

        // wrap: move pointer to 3, then 0/1/3 request and 1 withdraws
        src_q[2].push_back(9);
        wait_done(50, "wrap_setup");
        log_q.delete();
        src_q[0].push_back(200);
        src_q[1].push_back(-7);
        src_q[3].push_back(-2000);
        wait_rdy(3, "wrap_grant3");
        tick();
        src_q[1].delete();
        wait_done(100, "wrap");
        chk("wrap_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("wrap_first_id", log_q[0].id, 3);
            chk("wrap_first_sef", (log_q[0].s << 8) | (log_q[0].e << 5) | log_q[0].f,
                (1 << 8) | (6 << 5) | 31);
            chk("wrap_second_id", log_q[1].id, 0);
            chk("wrap_second_sef", (log_q[1].s << 8) | (log_q[1].e << 5) | log_q[1].f,
                (3 << 5) | 25);
        end
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
